// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage states and default widths for the pipeline stage registers
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} pipe_state_e;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_CTRL_W = 16;
  localparam int DEF_CNT_W  = 16;
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating up-counter that sticks at all-ones
module pipe_sat_counter #(
  parameter int CNT_W = pipe_pkg::DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  // count up on inc until every bit is set, then hold
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry skid-buffered pipeline register with flush and stall counter
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CTRL_W   = DEF_CTRL_W,
  parameter bit CLR_DATA = 1'b0,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);
  pipe_state_e       state;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              take_in, take_out;
  assign take_in   = in_valid && in_ready;
  assign take_out  = out_valid && out_ready;
  assign out_valid = state != EMPTY;
  assign out_data  = main_data;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  // entry FSM: main drives the outputs, skid absorbs the one entry accepted while stalled
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      main_data <= CLR_DATA ? '0 : main_data;
      skid_data <= CLR_DATA ? '0 : skid_data;
    end else begin
      case (state)
        EMPTY: begin
          in_ready <= 1'b1;
          if (take_in) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
            state     <= ONE;
          end
        end
        ONE: begin
          in_ready <= !(take_in && !take_out);
          if (take_in && take_out) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
          end else if (take_in) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
            state     <= TWO;
          end else if (take_out) state <= EMPTY;
        end
        TWO: begin
          in_ready <= take_out;
          if (take_out) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
            state     <= ONE;
          end
        end
        default: begin
          in_ready <= 1'b1;
          state    <= EMPTY;
        end
      endcase
    end
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (out_valid && !out_ready),
    .cnt    (stall_cnt)
  );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and scoreboarded checks of the skid-buffered stage register
module tb_pipe_stage_reg;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, flush = 1'b0;
  logic [63:0] in_data = '0, out_data;
  logic [15:0] in_ctrl = '0, out_ctrl;
  logic [3:0]  stall_cnt;
  int          compares = 0, fails = 0;
  logic [79:0] q[$];
  logic [79:0] head;

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(16), .CLR_DATA(1'b0), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .flush(flush), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [15:0] c, input logic r);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = r;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'h0);
    chk("rst_stall", 64'(stall_cnt), 64'h0);
    reset_n = 1'b1;
    #1 chk("in_ready_low_pre_edge", 64'(in_ready), 64'h0);
    tick();
    chk("in_ready_after_rst", 64'(in_ready), 64'h1);
    chk("idle_out_valid", 64'(out_valid), 64'h0);
    drive(1, 64'hA5, 16'h3, 1);
    tick();
    chk("a5_valid", 64'(out_valid), 64'h1);
    chk("a5_data", out_data, 64'hA5);
    chk("a5_ctrl", 64'(out_ctrl), 64'h3);
    drive(0, 64'h0, 16'h0, 1);
    tick();
    chk("bubble_valid", 64'(out_valid), 64'h0);
    chk("bubble_ctrl", 64'(out_ctrl), 64'h0);
    chk("bubble_data_held", out_data, 64'hA5);
    drive(1, 64'h11, 16'h1, 0);
    tick();
    chk("p11_data", out_data, 64'h11);
    chk("p11_in_ready", 64'(in_ready), 64'h1);
    drive(1, 64'h22, 16'h2, 0);
    tick();
    chk("two_in_ready", 64'(in_ready), 64'h0);
    chk("two_head_data", out_data, 64'h11);
    chk("two_head_ctrl", 64'(out_ctrl), 64'h1);
    chk("stall_one", 64'(stall_cnt), 64'h1);
    drive(1, 64'h33, 16'h3, 1);
    tick();
    chk("pop_second_data", out_data, 64'h22);
    chk("pop_second_ctrl", 64'(out_ctrl), 64'h2);
    chk("pop_in_ready", 64'(in_ready), 64'h1);
    chk("stall_held", 64'(stall_cnt), 64'h1);
    drive(0, 64'h0, 16'h0, 1);
    tick();
    chk("no_dup_valid", 64'(out_valid), 64'h0);
    drive(1, 64'h44, 16'h4, 0);
    tick();
    drive(1, 64'h55, 16'h5, 0);
    tick();
    chk("pre_flush_in_ready", 64'(in_ready), 64'h0);
    chk("pre_flush_stall", 64'(stall_cnt), 64'h2);
    drive(1, 64'h66, 16'h6, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'h0);
    chk("flush_ctrl", 64'(out_ctrl), 64'h0);
    chk("flush_in_ready", 64'(in_ready), 64'h1);
    chk("flush_keeps_stall", 64'(stall_cnt), 64'h3);
    chk("flush_data_held", out_data, 64'h44);
    drive(0, 64'h0, 16'h0, 1);
    tick();
    chk("flush_dropped", 64'(out_valid), 64'h0);
    drive(1, 64'h77, 16'h7, 1);
    tick();
    drive(1, 64'h88, 16'h8, 1);
    tick();
    chk("passthru_data", out_data, 64'h88);
    chk("passthru_ctrl", 64'(out_ctrl), 64'h8);
    chk("passthru_in_ready", 64'(in_ready), 64'h1);
    drive(0, 64'h0, 16'h0, 1);
    tick();
    chk("passthru_drain", 64'(out_valid), 64'h0);
    drive(1, 64'h99, 16'h9, 0);
    tick();
    drive(0, 64'h0, 16'h0, 0);
    for (int i = 0; i < 20; i++) tick();
    chk("stall_sat", 64'(stall_cnt), 64'hF);
    for (int i = 0; i < 3; i++) tick();
    chk("stall_no_wrap", 64'(stall_cnt), 64'hF);
    drive(1, 64'hAA, 16'hA, 0);
    tick();
    drive(0, 64'h0, 16'h0, 0);
    chk("async_pre_two", 64'(in_ready), 64'h0);
    #1 reset_n = 1'b0;
    #1;
    chk("async_valid", 64'(out_valid), 64'h0);
    chk("async_in_ready", 64'(in_ready), 64'h0);
    chk("async_data", out_data, 64'h0);
    chk("async_ctrl", 64'(out_ctrl), 64'h0);
    chk("async_stall", 64'(stall_cnt), 64'h0);
    #1 reset_n = 1'b1;
    tick();
    chk("rerst_in_ready", 64'(in_ready), 64'h1);
    chk("rerst_empty", 64'(out_valid), 64'h0);
    drive(1, 64'hBB, 16'hB, 1);
    tick();
    chk("rerst_data", out_data, 64'hBB);
    drive(0, 64'h0, 16'h0, 1);
    tick();
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 16'($urandom), 1'($urandom_range(0, 1)));
      chk("sb_valid", 64'(out_valid), 64'(q.size() != 0));
      if (out_valid && out_ready && q.size() != 0) begin
        head = q.pop_front();
        chk("sb_data", out_data, head[63:0]);
        chk("sb_ctrl", 64'(out_ctrl), 64'(head[79:64]));
      end
      if (in_valid && in_ready) q.push_back({in_ctrl, in_data});
      tick();
    end
    drive(0, 64'h0, 16'h0, 1);
    for (int i = 0; i < 4; i++) begin
      if (out_valid && q.size() != 0) begin
        head = q.pop_front();
        chk("drain_data", out_data, head[63:0]);
      end
      tick();
    end
    chk("drain_empty", 64'(out_valid), 64'h0);
    chk("drain_sb_empty", 64'(q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, 64, payload width; data fields are held through a flush unless CLR_DATA=1.
REQ-002 SHALL have parameter CTRL_W, 16, control-bit width; these bits are forced to 0 on flush and reset.
REQ-003 SHALL have parameter CLR_DATA, 0, 1 = also zero payload on flush.
REQ-004 SHALL have parameter CNT_W, 16, stall-counter width.
REQ-005 SHALL have port clk  in  1  rising-edge clock.
REQ-006 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port in_valid  in  1  upstream entry valid.
REQ-008 SHALL have port in_ready  out  1  stage can accept; registered.
REQ-009 SHALL have port in_data  in  DATA_W  upstream payload.
REQ-010 SHALL have port in_ctrl  in  CTRL_W  upstream control bits.
REQ-011 SHALL have port out_valid  out  1  downstream entry valid.
REQ-012 SHALL have port out_ready  in  1  downstream accepts.
REQ-013 SHALL have port out_data  out  DATA_W  held payload.
REQ-014 SHALL have port out_ctrl  out  CTRL_W  held control; 0 whenever out_valid=0.
REQ-015 SHALL have port flush  in  1  synchronous kill of all held entries.
REQ-016 SHALL have port stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0; saturating.

Function
REQ-017 SHALL hold two entries: main (drives out_*) and skid; FSM states EMPTY, ONE (main valid), TWO (main and skid valid).
REQ-018 SHALL register in_ready, which is 1 only when state is not TWO.
REQ-019 SHALL treat a transfer in as in_valid&in_ready, and a transfer out as out_valid&out_ready, both sampled at the rising edge.
REQ-020 EMPTY: on transfer in, SHALL load main and go to ONE (one-cycle latency, in to out_valid).
REQ-021 ONE: transfer in and out together SHALL reload main and stay ONE; in only SHALL load skid and go TWO; out only SHALL go EMPTY.
REQ-022 TWO: on transfer out, SHALL move skid to main and go ONE; no input is accepted in TWO.
REQ-023 SHALL keep FIFO order, with no loss and no duplication of entries.
REQ-024 flush=1 SHALL force state EMPTY next cycle, zero out_ctrl and skid ctrl, ignore any same-cycle transfer in, and zero data only if CLR_DATA=1.
REQ-025 flush SHALL take priority over all simultaneous handshakes.
REQ-026 out_valid=0 SHALL force out_ctrl=0 combinationally, so downstream sees a bubble.
REQ-027 stall_cnt SHALL increment when out_valid&~out_ready, saturate at all-ones, and never wrap.
REQ-028 flush SHALL NOT clear stall_cnt.

Reset
REQ-029 reset_n=0 SHALL asynchronously force: state EMPTY, in_ready=0, out_valid=0, out_ctrl=0, out_data=0, skid=0, stall_cnt=0.
REQ-030 SHALL raise in_ready on the first clock edge after reset_n deasserts.
REQ-031 Reset asserted mid-transfer SHALL discard all entries, with no partial update.

Structure
REQ-032 SHALL place the state enum (EMPTY/ONE/TWO) and the default widths in shared package pipe_pkg.
REQ-033 SHALL have one sub-module, pipe_sat_counter (parametrised CNT_W, inc, saturating), used for stall_cnt.
REQ-034 SHALL be replicable for IF/ID, ID/EX, EX/MEM and MEM/WB by width parameters alone.

Verification
REQ-035 Reset, then in_data=0xA5, in_ctrl=0x0003, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_ctrl=0x0003.
REQ-036 out_ready=0, push 0x11 then 0x22 -> in_ready=0 after the second push; out_ready=1 -> outputs 0x11 then 0x22, in order.
REQ-037 State TWO with flush=1 and in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, incoming entry dropped.
REQ-038 CNT_W=4, out_valid=1, out_ready=0 held 20 cycles -> stall_cnt=15 and stays at 15.
REQ-039 reset_n pulsed low between clock edges while in TWO -> out_valid=0 immediately, with no clock edge needed.
REQ-040 Random in_valid/out_ready, 10k cycles against a scoreboard -> zero ordering, loss or duplication errors.
